asynfifo_err_stat: RTL and testbench
====================================

ASYNFIFO_ERR_STAT -- requirements
Module: asynfifo_err_stat

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of each event counter.
REQ-002 SHALL have parameter NPORT, default 9, number of ports (index 0 = host, 1..8 = p0..p7).
REQ-003 SHALL have port i_clk, input, 1, sole clock; one clock, reset synchronous and active-high.
REQ-004 SHALL have port i_rst, input, 1, synchronous active-high reset sampled on i_clk rising edge.
REQ-005 SHALL have port i_rx_overflow_pulse, input, NPORT, rx FIFO overflow pulses, asynchronous to i_clk.
REQ-006 SHALL have port i_rx_underflow_pulse, input, NPORT, rx FIFO underflow pulses, synchronous to i_clk.
REQ-007 SHALL have port i_tx_overflow_pulse, input, NPORT, tx FIFO overflow pulses, synchronous to i_clk.
REQ-008 SHALL have port i_rd_req, input, 1, counter read request, held high until o_rd_ack.
REQ-009 SHALL have port i_rd_addr, input, 5, counter index: 0..8 rx overflow, 9..17 rx underflow, 18..26 tx overflow.
REQ-010 SHALL have port i_rd_clr, input, 1, clear addressed counter on read; sampled with i_rd_req.
REQ-011 SHALL have port o_rd_ack, output, 1, single-cycle read completion strobe.
REQ-012 SHALL have port o_rd_data, output, CNT_W, counter value, valid while o_rd_ack high.
REQ-013 SHALL have port o_err_summary, output, 3, sticky flags {tx_ovf, rx_udf, rx_ovf}, any port.

Function
REQ-014 Each i_rx_overflow_pulse bit SHALL pass through a 2-flop synchronizer then rising-edge detect; one event per rising edge; latency 3 cycles input-to-count.
REQ-015 i_rx_underflow_pulse and i_tx_overflow_pulse SHALL be rising-edge detected; latency 1 cycle input-to-count.
REQ-016 Each of 27 counters SHALL increment by 1 per detected event and saturate at 2^CNT_W-1 (no wrap).
REQ-017 Read FSM SHALL have states IDLE, CAPT, ACK: IDLE->CAPT when i_rd_req=1; CAPT latches counter[i_rd_addr] and i_rd_clr; CAPT->ACK unconditionally; ACK drives o_rd_ack=1 one cycle, then ->IDLE.
REQ-018 Read latency SHALL be 2 cycles from i_rd_req sampled high to o_rd_ack high; i_rd_req high in ACK cycle is ignored; next read starts no earlier than the cycle after ACK.
REQ-019 i_rd_addr > 26 SHALL return o_rd_data=0, ack normally, no counter affected.
REQ-020 Clear-on-read SHALL zero the addressed counter in the CAPT cycle; an event on that counter in the same cycle SHALL leave it at 1 (no event lost); returned value is pre-clear value.
REQ-021 o_err_summary bit SHALL set on any event of its class and clear only when a clear-on-read leaves all 9 counters of that class zero, or on reset.
REQ-022 o_rd_data SHALL hold last value outside ACK; verification shall check it only when o_rd_ack=1.

Reset
REQ-023 i_rst=1 SHALL zero all counters, synchronizer and edge-detect flops, o_err_summary, o_rd_data, o_rd_ack; FSM -> IDLE.
REQ-024 Reset asserted mid-read SHALL abort the read with no o_rd_ack and no clear applied.
REQ-025 Events arriving during reset SHALL be discarded; edge detectors restart from 0 after reset.

Configuration
REQ-026 Macro ASYNFIFO_ERR_IRQ_EN defined: SHALL add output o_irq, 1, a one-cycle pulse on any o_err_summary bit transition 0->1; reset value 0.
REQ-027 Macro undefined: o_irq port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Counter address map bases (0, 9, 18), max address 26 and default CNT_W SHALL reside in the shared switch constants package/header.
REQ-029 The existing signal_sync sub-module SHALL be instantiated per rx overflow bit; counters and FSM inline.

Verification
REQ-030 Reset, then read addr 5 -> o_rd_ack 2 cycles after req, o_rd_data=0, o_err_summary=000.
REQ-031 3 async pulses on i_rx_overflow_pulse[2] -> read addr 2 returns 3, o_err_summary=001.
REQ-032 CNT_W=4, 20 pulses on i_tx_overflow_pulse[0] -> addr 18 returns 15 (saturated).
REQ-033 Counter 9 = 5, read with i_rd_clr=1 and pulse on i_rx_underflow_pulse[0] in CAPT cycle -> returns 5, next read returns 1.
REQ-034 Read addr 30 -> o_rd_ack asserted, o_rd_data=0, all counters unchanged.
REQ-035 i_rst asserted in CAPT cycle -> no o_rd_ack, counter not cleared; with ASYNFIFO_ERR_IRQ_EN, first event after reset -> o_irq one-cycle pulse.

Source files
------------

// File: rtl/asynfifo_err_stat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : asynfifo_err_stat_pkg
// Description : Shared constants for the FIFO error statistics block:
//               counter address map, default counter width, read-FSM
//               state encoding and an address-to-class helper.
// Revision    : 1.0 - initial release
// ============================================================================
package asynfifo_err_stat_pkg;

    // Default event counter width
    localparam int C_CNT_W_DEF       = 16;

    // One counter per port per error class; host plus p0..p7
    localparam int C_PORTS_PER_CLASS = 9;
    localparam int C_NUM_CLASS       = 3;
    localparam int C_NUM_CNT         = C_PORTS_PER_CLASS * C_NUM_CLASS;

    // Counter address map
    localparam logic [4:0] C_RXO_BASE = 5'd0;
    localparam logic [4:0] C_RXU_BASE = 5'd9;
    localparam logic [4:0] C_TXO_BASE = 5'd18;
    localparam logic [4:0] C_MAX_ADDR = 5'd26;

    // Error class indices, also the bit positions in the summary vector
    localparam logic [1:0] C_CLS_RXO = 2'd0;
    localparam logic [1:0] C_CLS_RXU = 2'd1;
    localparam logic [1:0] C_CLS_TXO = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAPT = 2'd1,
        ST_ACK  = 2'd2
    } rd_state_t;

    // Error class that a (valid) counter address belongs to
    function automatic logic [1:0] addr_class(input logic [4:0] addr);
        if (addr >= C_TXO_BASE) begin
            return C_CLS_TXO;
        end else if (addr >= C_RXU_BASE) begin
            return C_CLS_RXU;
        end
        return C_CLS_RXO;
    endfunction

endpackage
`default_nettype wire

// File: rtl/asynfifo_err_stat_signal_sync.sv
`default_nettype none
// ============================================================================
// Module      : signal_sync
// Description : Two-flop synchronizer bringing a single asynchronous level
//               into the i_clk domain.
// Ports       : i_clk - destination clock
//               i_rst - synchronous active-high reset
//               i_d   - asynchronous input level
//               o_q   - synchronized output level
// Revision    : 1.0 - initial release
// ============================================================================
module signal_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/asynfifo_err_stat.sv
`default_nettype none
// ============================================================================
// Module      : asynfifo_err_stat
// Description : FIFO error statistics. Counts rx-overflow (asynchronous
//               pulses, synchronized), rx-underflow and tx-overflow events
//               per port in 27 saturating counters, exposes them through a
//               request/acknowledge read port with optional clear-on-read,
//               and keeps sticky per-class error summary flags.
// Ports       : i_clk / i_rst          - clock, synchronous active-high reset
//               i_rx_overflow_pulse    - async rx overflow pulses per port
//               i_rx_underflow_pulse   - rx underflow pulses per port
//               i_tx_overflow_pulse    - tx overflow pulses per port
//               i_rd_req/addr/clr      - counter read request, index, clear
//               o_rd_ack / o_rd_data   - read strobe and counter value
//               o_err_summary          - sticky {tx_ovf, rx_udf, rx_ovf}
//               o_irq                  - summary rise pulse (optional)
// Config      : ASYNFIFO_ERR_IRQ_EN - when defined adds o_irq, a one-cycle
//               pulse whenever any o_err_summary bit goes 0->1.
// Revision    : 1.0 - initial release
// ============================================================================
module asynfifo_err_stat
    import asynfifo_err_stat_pkg::*;
#(
    parameter int CNT_W = C_CNT_W_DEF,
    parameter int NPORT = C_PORTS_PER_CLASS
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [NPORT-1:0] i_rx_overflow_pulse,
    input  logic [NPORT-1:0] i_rx_underflow_pulse,
    input  logic [NPORT-1:0] i_tx_overflow_pulse,
    input  logic             i_rd_req,
    input  logic [4:0]       i_rd_addr,
    input  logic             i_rd_clr,
    output logic             o_rd_ack,
    output logic [CNT_W-1:0] o_rd_data,
    output logic [2:0]       o_err_summary
`ifdef ASYNFIFO_ERR_IRQ_EN
    ,
    output logic             o_irq
`endif
);

    // ------------------------------------------------------------------
    // Event levels per class, padded to the fixed 9-port address map
    // ------------------------------------------------------------------
    logic [C_PORTS_PER_CLASS-1:0] w_rxo_lvl;
    logic [C_PORTS_PER_CLASS-1:0] w_rxu_lvl;
    logic [C_PORTS_PER_CLASS-1:0] w_txo_lvl;

    for (genvar p = 0; p < C_PORTS_PER_CLASS; p++) begin : g_port
        if (p < NPORT) begin : g_used
            signal_sync u_rxo_sync (
                .i_clk (i_clk),
                .i_rst (i_rst),
                .i_d   (i_rx_overflow_pulse[p]),
                .o_q   (w_rxo_lvl[p])
            );
            assign w_rxu_lvl[p] = i_rx_underflow_pulse[p];
            assign w_txo_lvl[p] = i_tx_overflow_pulse[p];
        end else begin : g_pad
            assign w_rxo_lvl[p] = 1'b0;
            assign w_rxu_lvl[p] = 1'b0;
            assign w_txo_lvl[p] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Rising-edge detection. Bit order matches the counter address map,
    // so w_evt[k] is the event for counter k.
    // ------------------------------------------------------------------
    logic [C_NUM_CNT-1:0] w_lvl;
    logic [C_NUM_CNT-1:0] r_lvl_d;
    logic [C_NUM_CNT-1:0] w_evt;

    assign w_lvl = {w_txo_lvl, w_rxu_lvl, w_rxo_lvl};
    assign w_evt = w_lvl & ~r_lvl_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lvl_d <= '0;
        end else begin
            r_lvl_d <= w_lvl;
        end
    end

    // ------------------------------------------------------------------
    // Read FSM state and captured request
    // ------------------------------------------------------------------
    rd_state_t        r_state;
    logic [4:0]       r_addr;
    logic             r_clr;
    logic             r_ack;
    logic [CNT_W-1:0] r_rd_data;

    logic [CNT_W-1:0] r_cnt     [C_NUM_CNT];
    logic [CNT_W-1:0] w_cnt_nxt [C_NUM_CNT];

    logic             w_addr_ok;
    logic             w_clr_act;
    logic [1:0]       w_cls;
    logic [CNT_W-1:0] w_rd_val;

    assign w_addr_ok = (r_addr <= C_MAX_ADDR);
    assign w_clr_act = (r_state == ST_CAPT) && r_clr && w_addr_ok;
    assign w_cls     = addr_class(r_addr);
    assign w_rd_val  = w_addr_ok ? r_cnt[r_addr] : '0;

    // ------------------------------------------------------------------
    // Counter next-state: clear first, then count, so an event landing in
    // the clearing cycle leaves the counter at 1 instead of being lost.
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < C_NUM_CNT; k++) begin
            w_cnt_nxt[k] = r_cnt[k];
            if (w_clr_act && (r_addr == 5'(k))) begin
                w_cnt_nxt[k] = '0;
            end
            if (w_evt[k] && (w_cnt_nxt[k] != '1)) begin
                w_cnt_nxt[k] = w_cnt_nxt[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < C_NUM_CNT; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < C_NUM_CNT; k++) begin
                r_cnt[k] <= w_cnt_nxt[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky summary. A class flag drops only when a clear-on-read of that
    // class leaves every counter of the class at zero.
    // ------------------------------------------------------------------
    logic [2:0] r_sum;
    logic [2:0] w_sum_set;
    logic [2:0] w_cls_zero;
    logic [2:0] w_sum_clr;
    logic [2:0] w_sum_nxt;

    assign w_sum_set = {|w_evt[26:18], |w_evt[17:9], |w_evt[8:0]};

    always_comb begin
        w_cls_zero = '1;
        w_sum_clr  = '0;
        for (int c = 0; c < C_NUM_CLASS; c++) begin
            for (int p = 0; p < C_PORTS_PER_CLASS; p++) begin
                if (w_cnt_nxt[c * C_PORTS_PER_CLASS + p] != '0) begin
                    w_cls_zero[c] = 1'b0;
                end
            end
            w_sum_clr[c] = w_clr_act && (w_cls == 2'(c)) && w_cls_zero[c];
        end
    end

    assign w_sum_nxt = (r_sum | w_sum_set) & ~w_sum_clr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_sum_nxt;
        end
    end

    assign o_err_summary = r_sum;

`ifdef ASYNFIFO_ERR_IRQ_EN
    logic r_irq;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(w_sum_nxt & ~r_sum);
        end
    end

    assign o_irq = r_irq;
`endif

    // ------------------------------------------------------------------
    // Read FSM. The requester holds address and clear stable until the
    // acknowledge, so they are taken on the IDLE->CAPT edge and the CAPT
    // cycle works from the registered copy. Reset during CAPT suppresses
    // both the acknowledge and the clear.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_clr     <= 1'b0;
            r_ack     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_rd_req) begin
                        r_addr  <= i_rd_addr;
                        r_clr   <= i_rd_clr;
                        r_state <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    r_rd_data <= w_rd_val;
                    r_ack     <= 1'b1;
                    r_state   <= ST_ACK;
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rd_ack  = r_ack;
    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_asynfifo_err_stat.sv
`default_nettype none
// ============================================================================
// Module      : tb_asynfifo_err_stat
// Description : Directed self-checking bench for asynfifo_err_stat with a
//               4-bit counter width so saturation is reachable quickly.
//               Compile with ASYNFIFO_ERR_IRQ_EN to also check o_irq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asynfifo_err_stat;

    localparam int CNT_W = 4;
    localparam int NPORT = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic [NPORT-1:0] rxo;
    logic [NPORT-1:0] rxu;
    logic [NPORT-1:0] txo;
    logic             req;
    logic [4:0]       addr;
    logic             clr;
    logic             ack;
    logic [CNT_W-1:0] data;
    logic [2:0]       sum;
`ifdef ASYNFIFO_ERR_IRQ_EN
    logic             irq;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    asynfifo_err_stat #(
        .CNT_W (CNT_W),
        .NPORT (NPORT)
    ) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_rx_overflow_pulse  (rxo),
        .i_rx_underflow_pulse (rxu),
        .i_tx_overflow_pulse  (txo),
        .i_rd_req             (req),
        .i_rd_addr            (addr),
        .i_rd_clr             (clr),
        .o_rd_ack             (ack),
        .o_rd_data            (data),
        .o_err_summary        (sum)
`ifdef ASYNFIFO_ERR_IRQ_EN
        ,
        .o_irq                (irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full read transaction; optionally raises rx underflow p0 in the CAPT cycle
    task automatic do_read(input string tag, input logic [4:0] a, input logic c,
                           input logic capt_pulse, input logic [31:0] exp);
        req  = 1'b1;
        addr = a;
        clr  = c;
        tick();
        check({tag, "_ack_early"}, 32'(ack), 32'd0);
        if (capt_pulse) rxu[0] = 1'b1;
        tick();
        check({tag, "_ack"}, 32'(ack), 32'd1);
        check({tag, "_data"}, 32'(data), exp);
        req = 1'b0;
        clr = 1'b0;
        if (capt_pulse) rxu[0] = 1'b0;
        tick();
        check({tag, "_ack_drop"}, 32'(ack), 32'd0);
    endtask

    // Single-cycle pulses on a synchronous input: cls 0 = rx underflow, 1 = tx overflow
    task automatic pulse_sync(input int cls, input int p, input int n);
        for (int i = 0; i < n; i++) begin
            if (cls == 0) rxu[p] = 1'b1; else txo[p] = 1'b1;
            tick();
            if (cls == 0) rxu[p] = 1'b0; else txo[p] = 1'b0;
            tick();
        end
    endtask

    // Pulses on an rx overflow bit placed off the clock grid
    task automatic pulse_async(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            #3 rxo[p] = 1'b1;
            repeat (2) @(posedge clk);
            #3 rxo[p] = 1'b0;
            repeat (2) @(posedge clk);
        end
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        rxo  = '0;
        rxu  = '0;
        txo  = '0;
        req  = 1'b0;
        addr = '0;
        clr  = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
`ifdef ASYNFIFO_ERR_IRQ_EN
        check("rst_irq", 32'(irq), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Empty counter read
        do_read("r5", 5'd5, 1'b0, 1'b0, 32'd0);
        check("sum_idle", 32'(sum), 32'd0);

        // Three asynchronous rx overflow pulses on port index 2
        pulse_async(2, 3);
        repeat (4) tick();
        do_read("r2", 5'd2, 1'b0, 1'b0, 32'd3);
        check("sum_rxo", 32'(sum), 32'b001);

        // Saturation of a 4-bit counter
        pulse_sync(1, 0, 20);
        do_read("r18", 5'd18, 1'b0, 1'b0, 32'd15);
        check("sum_txo", 32'(sum), 32'b101);

        // Clear-on-read with a coincident event
        pulse_sync(0, 0, 5);
        check("sum_all", 32'(sum), 32'b111);
        do_read("r9clr", 5'd9, 1'b1, 1'b1, 32'd5);
        do_read("r9", 5'd9, 1'b0, 1'b0, 32'd1);

        // Out-of-range address, even with clear, touches nothing
        do_read("r30", 5'd30, 1'b1, 1'b0, 32'd0);
        do_read("r2b", 5'd2, 1'b0, 1'b0, 32'd3);
        do_read("r18b", 5'd18, 1'b0, 1'b0, 32'd15);
        check("sum_r30", 32'(sum), 32'b111);

        // Summary bits drop only when a class is fully cleared
        do_read("r2clr", 5'd2, 1'b1, 1'b0, 32'd3);
        check("sum_clr_rxo", 32'(sum), 32'b110);
        do_read("r18clr", 5'd18, 1'b1, 1'b0, 32'd15);
        check("sum_clr_txo", 32'(sum), 32'b010);
        do_read("r9clr2", 5'd9, 1'b1, 1'b0, 32'd1);
        check("sum_clr_rxu", 32'(sum), 32'b000);

        pulse_sync(0, 3, 1);
        pulse_sync(0, 4, 1);
        check("sum_two", 32'(sum), 32'b010);
        do_read("r12clr", 5'd12, 1'b1, 1'b0, 32'd1);
        check("sum_partial", 32'(sum), 32'b010);
        do_read("r13clr", 5'd13, 1'b1, 1'b0, 32'd1);
        check("sum_full", 32'(sum), 32'b000);

        // Reset during CAPT aborts the read; edges during reset are dropped
        pulse_sync(0, 1, 2);
        req  = 1'b1;
        addr = 5'd10;
        clr  = 1'b1;
        tick();
        check("abort_capt_ack", 32'(ack), 32'd0);
        rst    = 1'b1;
        txo[1] = 1'b1;
        tick();
        check("abort_ack", 32'(ack), 32'd0);
        req    = 1'b0;
        clr    = 1'b0;
        txo[1] = 1'b0;
        tick();
        txo[1] = 1'b1;
        tick();
        txo[1] = 1'b0;
        rst    = 1'b0;
        tick();
        check("post_rst_ack", 32'(ack), 32'd0);
        check("post_rst_sum", 32'(sum), 32'd0);
        do_read("r10", 5'd10, 1'b0, 1'b0, 32'd0);
        do_read("r19", 5'd19, 1'b0, 1'b0, 32'd0);

        // Synchronous path latency: one cycle to count
        rxu[5] = 1'b1;
        tick();
        check("udf_lat", 32'(sum), 32'b010);
`ifdef ASYNFIFO_ERR_IRQ_EN
        check("irq_udf", 32'(irq), 32'd1);
`endif
        rxu[5] = 1'b0;
        tick();
`ifdef ASYNFIFO_ERR_IRQ_EN
        check("irq_udf_end", 32'(irq), 32'd0);
`endif

        // Asynchronous path latency: three cycles to count
        rxo[4] = 1'b1;
        tick();
        tick();
        check("ovf_lat2", 32'(sum), 32'b010);
        tick();
        check("ovf_lat3", 32'(sum), 32'b011);
`ifdef ASYNFIFO_ERR_IRQ_EN
        check("irq_ovf", 32'(irq), 32'd1);
`endif
        rxo[4] = 1'b0;
        tick();
`ifdef ASYNFIFO_ERR_IRQ_EN
        check("irq_ovf_end", 32'(irq), 32'd0);
`endif
        repeat (3) tick();
        do_read("r13", 5'd13, 1'b0, 1'b0, 32'd0);
        do_read("r14", 5'd14, 1'b0, 1'b0, 32'd1);
        do_read("r4", 5'd4, 1'b0, 1'b0, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
